// File: rtl/raid_stripe_engine.sv
// RAID stripe engine: assembles rotating-parity rows for block writes and
// captures, reconstructs and parity-checks rows for block reads.
module raid_stripe_engine #(
    parameter int NUM_SD          = 3,
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_BLOCK = 128
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [31:0]                stripe_no,
    input  logic [2*NUM_SD-1:0]        sd_error,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [NUM_SD*DATA_W-1:0]   sd_in,
    output logic                       sd_in_valid,
    input  logic                       sd_ready,
    input  logic [NUM_SD*DATA_W-1:0]   sd_out,
    input  logic                       sd_out_valid,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       degraded,
    output logic                       fatal,
    output logic                       parity_err
);
    localparam int RW    = NUM_SD * DATA_W;
    localparam int LN_W  = $clog2(NUM_SD);
    localparam int ROW_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [LN_W-1:0]  LAST_WORD = LN_W'(NUM_SD - 2);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(WORDS_PER_BLOCK - 1);
    localparam logic [LN_W:0]    CNT_ONE   = (LN_W+1)'(1);
    localparam logic [LN_W:0]    CNT_TWO   = (LN_W+1)'(2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_COLLECT = 3'd1,
        W_ISSUE   = 3'd2,
        R_WAIT    = 3'd3,
        R_EMIT    = 3'd4,
        DONE      = 3'd5
    } state_t;

    function automatic logic [DATA_W-1:0] get_lane(input logic [RW-1:0] row, input logic [LN_W-1:0] idx);
        get_lane = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_SD; i++)
            if (LN_W'(i) == idx) get_lane = row[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [RW-1:0] set_lane(input logic [RW-1:0] row, input logic [LN_W-1:0] idx,
                                               input logic [DATA_W-1:0] val);
        set_lane = row;
        for (int i = 0; i < NUM_SD; i++)
            if (LN_W'(i) == idx) set_lane[i*DATA_W +: DATA_W] = val;
    endfunction

    // XOR of every lane not flagged in skip: parity check and reconstruction.
    function automatic logic [DATA_W-1:0] xor_lanes(input logic [RW-1:0] row, input logic [NUM_SD-1:0] skip);
        xor_lanes = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_SD; i++)
            if (!skip[i]) xor_lanes = xor_lanes ^ row[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [RW-1:0] rebuild(input logic [RW-1:0] row, input logic [NUM_SD-1:0] mask);
        logic [DATA_W-1:0] rec;
        rec     = xor_lanes(row, mask);
        rebuild = row;
        for (int i = 0; i < NUM_SD; i++)
            if (mask[i]) rebuild[i*DATA_W +: DATA_W] = rec;
    endfunction

    // Data word k lives in lane k, shifted up by one once past the parity lane.
    function automatic logic [LN_W-1:0] data_lane(input logic [LN_W-1:0] k, input logic [LN_W-1:0] p);
        if (k < p) data_lane = k;
        else       data_lane = k + LN_W'(1);
    endfunction

    function automatic logic [LN_W:0] fail_count(input logic [NUM_SD-1:0] mask);
        fail_count = {(LN_W+1){1'b0}};
        for (int i = 0; i < NUM_SD; i++)
            fail_count = fail_count + (LN_W+1)'(mask[i]);
    endfunction

    state_t             state_r, state_nxt_s;
    logic               mode_r, mode_nxt_s;
    logic [LN_W-1:0]    par_r, par_nxt_s;
    logic [NUM_SD-1:0]  mask_r, mask_nxt_s, start_mask_s;
    logic [LN_W:0]      start_cnt_s;
    logic [RW-1:0]      row_buf_r, row_buf_nxt_s;
    logic [DATA_W-1:0]  acc_r, acc_nxt_s, out_data_r, out_data_nxt_s;
    logic [ROW_W-1:0]   row_cnt_r, row_cnt_nxt_s;
    logic [LN_W-1:0]    word_cnt_r, word_cnt_nxt_s;
    logic               deg_r, deg_nxt_s, fatal_r, fatal_nxt_s, perr_r, perr_nxt_s;
    logic               in_ready_r, sd_in_valid_r, out_valid_r, busy_r, done_r;

    // Per-lane failure flags decoded from the 2-bit error codes.
    always_comb begin
        start_mask_s = {NUM_SD{1'b0}};
        for (int i = 0; i < NUM_SD; i++)
            start_mask_s[i] = |sd_error[2*i +: 2];
        start_cnt_s = fail_count(start_mask_s);
    end

    // Next-state and datapath update for the stripe sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        mode_nxt_s     = mode_r;
        par_nxt_s      = par_r;
        mask_nxt_s     = mask_r;
        row_buf_nxt_s  = row_buf_r;
        acc_nxt_s      = acc_r;
        row_cnt_nxt_s  = row_cnt_r;
        word_cnt_nxt_s = word_cnt_r;
        deg_nxt_s      = deg_r;
        fatal_nxt_s    = fatal_r;
        perr_nxt_s     = perr_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    mode_nxt_s     = mode;
                    par_nxt_s      = LN_W'(stripe_no % 32'(NUM_SD));
                    mask_nxt_s     = start_mask_s;
                    row_buf_nxt_s  = {RW{1'b0}};
                    acc_nxt_s      = {DATA_W{1'b0}};
                    row_cnt_nxt_s  = {ROW_W{1'b0}};
                    word_cnt_nxt_s = {LN_W{1'b0}};
                    deg_nxt_s      = (start_cnt_s == CNT_ONE);
                    fatal_nxt_s    = (start_cnt_s >= CNT_TWO);
                    perr_nxt_s     = 1'b0;
                    if (start_cnt_s >= CNT_TWO) state_nxt_s = DONE;
                    else if (mode)              state_nxt_s = R_WAIT;
                    else                        state_nxt_s = W_COLLECT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            W_COLLECT: begin
                if (in_valid && in_ready_r) begin
                    row_buf_nxt_s = set_lane(row_buf_r, data_lane(word_cnt_r, par_r), in_data);
                    acc_nxt_s     = acc_r ^ in_data;
                    if (word_cnt_r == LAST_WORD) begin
                        row_buf_nxt_s  = set_lane(row_buf_nxt_s, par_r, acc_nxt_s);
                        word_cnt_nxt_s = {LN_W{1'b0}};
                        state_nxt_s    = W_ISSUE;
                    end else begin
                        word_cnt_nxt_s = word_cnt_r + LN_W'(1);
                    end
                end else begin
                    state_nxt_s = W_COLLECT;
                end
            end
            W_ISSUE: begin
                if (sd_ready && sd_in_valid_r) begin
                    if (row_cnt_r == LAST_ROW) begin
                        state_nxt_s = DONE;
                    end else begin
                        row_cnt_nxt_s = row_cnt_r + ROW_W'(1);
                        row_buf_nxt_s = {RW{1'b0}};
                        acc_nxt_s     = {DATA_W{1'b0}};
                        state_nxt_s   = W_COLLECT;
                    end
                end else begin
                    state_nxt_s = W_ISSUE;
                end
            end
            R_WAIT: begin
                if (sd_out_valid) begin
                    row_buf_nxt_s  = rebuild(sd_out, mask_r);
                    word_cnt_nxt_s = {LN_W{1'b0}};
                    state_nxt_s    = R_EMIT;
                    if ((mask_r == {NUM_SD{1'b0}}) && (xor_lanes(sd_out, {NUM_SD{1'b0}}) != {DATA_W{1'b0}}))
                        perr_nxt_s = 1'b1;
                    else
                        perr_nxt_s = perr_r;
                end else begin
                    state_nxt_s = R_WAIT;
                end
            end
            R_EMIT: begin
                if (out_ready && out_valid_r) begin
                    if (word_cnt_r != LAST_WORD) begin
                        word_cnt_nxt_s = word_cnt_r + LN_W'(1);
                    end else if (row_cnt_r == LAST_ROW) begin
                        state_nxt_s = DONE;
                    end else begin
                        row_cnt_nxt_s  = row_cnt_r + ROW_W'(1);
                        row_buf_nxt_s  = {RW{1'b0}};
                        acc_nxt_s      = {DATA_W{1'b0}};
                        word_cnt_nxt_s = {LN_W{1'b0}};
                        state_nxt_s    = R_WAIT;
                    end
                end else begin
                    state_nxt_s = R_EMIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Read word presented next; held while the consumer stalls.
    always_comb begin
        if (state_nxt_s == R_EMIT)
            out_data_nxt_s = get_lane(row_buf_nxt_s, data_lane(word_cnt_nxt_s, par_nxt_s));
        else
            out_data_nxt_s = out_data_r;
    end

    // State, datapath and registered handshake/status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r       <= IDLE;
            mode_r        <= 1'b0;
            par_r         <= {LN_W{1'b0}};
            mask_r        <= {NUM_SD{1'b0}};
            row_buf_r     <= {RW{1'b0}};
            acc_r         <= {DATA_W{1'b0}};
            row_cnt_r     <= {ROW_W{1'b0}};
            word_cnt_r    <= {LN_W{1'b0}};
            deg_r         <= 1'b0;
            fatal_r       <= 1'b0;
            perr_r        <= 1'b0;
            out_data_r    <= {DATA_W{1'b0}};
            in_ready_r    <= 1'b0;
            sd_in_valid_r <= 1'b0;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            mode_r        <= mode_nxt_s;
            par_r         <= par_nxt_s;
            mask_r        <= mask_nxt_s;
            row_buf_r     <= row_buf_nxt_s;
            acc_r         <= acc_nxt_s;
            row_cnt_r     <= row_cnt_nxt_s;
            word_cnt_r    <= word_cnt_nxt_s;
            deg_r         <= deg_nxt_s;
            fatal_r       <= fatal_nxt_s;
            perr_r        <= perr_nxt_s;
            out_data_r    <= out_data_nxt_s;
            in_ready_r    <= (state_nxt_s == W_COLLECT);
            sd_in_valid_r <= (state_nxt_s == W_ISSUE);
            out_valid_r   <= (state_nxt_s == R_EMIT);
            busy_r        <= (state_nxt_s != IDLE);
            done_r        <= (state_nxt_s == DONE);
        end
    end

    assign in_ready    = in_ready_r;
    assign sd_in       = row_buf_r;
    assign sd_in_valid = sd_in_valid_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign degraded    = deg_r;
    assign fatal       = fatal_r;
    assign parity_err  = perr_r;
endmodule
